// File: rtl/instr_prefetch_unit_pkg.sv
// Shared types and defaults for the instruction prefetch unit.
package instr_prefetch_unit_pkg;

  typedef enum logic {
    REQ_IDLE = 1'b0,
    REQ_PEND = 1'b1
  } req_state_e;

  localparam int PF_PC_STEP_DEFAULT = 4;

endpackage

// File: rtl/instr_prefetch_unit_pf_fifo.sv
// Synchronous FIFO with push, pop, clear and count. The head is readable with no delay.
// Clear has priority over push and pop. A push into a full FIFO is ignored unless a pop happens in the same cycle.
module pf_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clear_i,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           push_dat_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           head_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wptr_q, rptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push, do_pop;

  assign do_pop  = pop_i && (count_q != '0);
  assign do_push = push_i && ((count_q != CW'(DEPTH)) || do_pop);

  function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] ptr);
    return (ptr == PW'(DEPTH - 1)) ? '0 : ptr + 1'b1;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (clear_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wptr_q] <= push_dat_i;
        wptr_q        <= wrap_inc(wptr_q);
      end
      if (do_pop) rptr_q <= wrap_inc(rptr_q);
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  assign head_o  = mem_q[rptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/instr_prefetch_unit.sv
// Prefetches instructions with several requests in flight and buffers the replies in a FIFO. Data appears one cycle after the response edge.
// New requests are throttled by outstanding and buffer credit. A jump flushes the buffer and drops stale in-flight replies.
module instr_prefetch_unit
  import instr_prefetch_unit_pkg::*;
#(
  parameter int                    ADDR_WIDTH      = 32,
  parameter int                    DATA_WIDTH      = 32,
  parameter int                    DEPTH           = 4,
  parameter int                    MAX_OUTSTANDING = 2,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC        = '0,
  parameter int                    PC_STEP         = PF_PC_STEP_DEFAULT
) (
  input  logic                         clk,
  input  logic                         rst,
  output logic [ADDR_WIDTH-1:0]        instr_addr_out,
  output logic                         instr_addr_valid_out,
  input  logic                         instr_ready_in,
  input  logic                         instr_valid_in,
  input  logic [DATA_WIDTH-1:0]        instr_in,
  input  logic                         pf_jump_flag_in,
  input  logic [ADDR_WIDTH-1:0]        pf_jump_addr_in,
  output logic [DATA_WIDTH-1:0]        pf_instr_out,
  output logic [ADDR_WIDTH-1:0]        pf_instr_addr_out,
  output logic                         pf_instr_valid_out,
  input  logic                         pf_instr_ready_in,
  output logic [$clog2(DEPTH):0]       pf_count_out,
  output logic                         pf_err_out
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);

  req_state_e            state_q;
  logic [ADDR_WIDTH-1:0] addr_q, pc_q, pc_nxt;
  logic                  vld_q, stale_q, err_q;
  logic [OW-1:0]         out_q, out_d, disc_q, disc_d;

  logic                  acc, resp_ok, buf_push, buf_pop, tag_push, tag_pop, credit;
  logic [31:0]           in_flight;
  logic [CW-1:0]         buf_count;
  logic [OW-1:0]         tag_count;
  logic [ADDR_WIDTH-1:0] tag_head;
  logic [ADDR_WIDTH+DATA_WIDTH-1:0] buf_head;

  assign acc       = vld_q & instr_ready_in;
  assign resp_ok   = instr_valid_in & (out_q != '0);
  assign buf_push  = resp_ok & (disc_q == '0) & ~pf_jump_flag_in;
  assign buf_pop   = pf_instr_valid_out & pf_instr_ready_in & ~pf_jump_flag_in;
  assign tag_push  = acc & ~stale_q;
  assign tag_pop   = resp_ok & (disc_q == '0) & (tag_count != '0);
  assign in_flight = 32'(out_q) + 32'(acc);
  assign credit    = ((in_flight + 32'(buf_count)) < 32'(DEPTH)) &&
                     (in_flight < 32'(MAX_OUTSTANDING));
  // A stale request completing after a jump must not advance the post-jump pc.
  assign pc_nxt    = (acc && !stale_q) ? pc_q + ADDR_WIDTH'(PC_STEP) : pc_q;

  always_comb begin
    out_d = out_q + OW'(acc) - OW'(resp_ok);
    if (pf_jump_flag_in) disc_d = out_d;
    else disc_d = disc_q - OW'(resp_ok && (disc_q != '0)) + OW'(acc && stale_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= REQ_IDLE;
      vld_q   <= 1'b0;
      addr_q  <= RESET_PC;
      pc_q    <= RESET_PC;
      out_q   <= '0;
      disc_q  <= '0;
      stale_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      out_q   <= out_d;
      disc_q  <= disc_d;
      pc_q    <= pf_jump_flag_in ? pf_jump_addr_in : pc_nxt;
      stale_q <= pf_jump_flag_in ? (vld_q & ~acc) : (stale_q & ~acc);
      if (instr_valid_in && (out_q == '0)) err_q <= 1'b1;
      case (state_q)
        REQ_IDLE: begin
          if (credit && !pf_jump_flag_in) begin
            state_q <= REQ_PEND;
            vld_q   <= 1'b1;
            addr_q  <= pc_q;
          end
        end
        REQ_PEND: begin
          if (acc) begin
            if (credit && !pf_jump_flag_in) begin
              addr_q <= pc_nxt;
            end else begin
              state_q <= REQ_IDLE;
              vld_q   <= 1'b0;
            end
          end
        end
        default: state_q <= REQ_IDLE;
      endcase
    end
  end

  pf_fifo #(.WIDTH(ADDR_WIDTH), .DEPTH(MAX_OUTSTANDING)) u_tag_q (
    .clk        (clk),
    .rst        (rst),
    .clear_i    (pf_jump_flag_in),
    .push_i     (tag_push),
    .push_dat_i (addr_q),
    .pop_i      (tag_pop),
    .head_o     (tag_head),
    .count_o    (tag_count)
  );

  pf_fifo #(.WIDTH(ADDR_WIDTH + DATA_WIDTH), .DEPTH(DEPTH)) u_instr_buf (
    .clk        (clk),
    .rst        (rst),
    .clear_i    (pf_jump_flag_in),
    .push_i     (buf_push),
    .push_dat_i ({tag_head, instr_in}),
    .pop_i      (buf_pop),
    .head_o     (buf_head),
    .count_o    (buf_count)
  );

  assign instr_addr_out       = addr_q;
  assign instr_addr_valid_out = vld_q;
  assign pf_instr_addr_out    = buf_head[ADDR_WIDTH+DATA_WIDTH-1:DATA_WIDTH];
  assign pf_instr_out         = buf_head[DATA_WIDTH-1:0];
  assign pf_instr_valid_out   = (buf_count != '0);
  assign pf_count_out         = buf_count;
  assign pf_err_out           = err_q;

endmodule

// File: tb/tb_instr_prefetch_unit.sv
// Randomised and directed bench for instr_prefetch_unit against an epoch-based reference model.
module tb_instr_prefetch_unit;
  localparam int AW = 32, DW = 32, DEPTH = 4, MAXO = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] instr_addr_out;
  logic          instr_addr_valid_out;
  logic          instr_ready_in;
  logic          instr_valid_in;
  logic [DW-1:0] instr_in;
  logic          pf_jump_flag_in;
  logic [AW-1:0] pf_jump_addr_in;
  logic [DW-1:0] pf_instr_out;
  logic [AW-1:0] pf_instr_addr_out;
  logic          pf_instr_valid_out;
  logic          pf_instr_ready_in;
  logic [2:0]    pf_count_out;
  logic          pf_err_out;

  always #5 clk = ~clk;

  instr_prefetch_unit #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO),
    .RESET_PC('0), .PC_STEP(4)
  ) dut (
    .clk(clk), .rst(rst),
    .instr_addr_out(instr_addr_out), .instr_addr_valid_out(instr_addr_valid_out),
    .instr_ready_in(instr_ready_in), .instr_valid_in(instr_valid_in), .instr_in(instr_in),
    .pf_jump_flag_in(pf_jump_flag_in), .pf_jump_addr_in(pf_jump_addr_in),
    .pf_instr_out(pf_instr_out), .pf_instr_addr_out(pf_instr_addr_out),
    .pf_instr_valid_out(pf_instr_valid_out), .pf_instr_ready_in(pf_instr_ready_in),
    .pf_count_out(pf_count_out), .pf_err_out(pf_err_out)
  );

  typedef struct { logic [31:0] addr; logic [31:0] data; int epoch; int due; } req_t;
  typedef struct { logic [31:0] addr; logic [31:0] data; } ent_t;

  req_t        mem_q[$];
  ent_t        exp_q[$];
  logic [31:0] acc_log[$];
  logic [31:0] pop_log[$];
  int          epoch, req_epoch, cyc, tests, fails;
  logic [31:0] exp_pc, prev_addr;
  bit          model_err, prev_hold;
  int          rdy_pct, cons_pct, jump_pm, lat_min, lat_max;
  bit          jump_req, err_req;
  logic [31:0] jump_tgt;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    mem_q.delete(); exp_q.delete(); acc_log.delete(); pop_log.delete();
    epoch = 0; req_epoch = 0; exp_pc = 32'h0; model_err = 0; prev_hold = 0; prev_addr = 0;
  endtask

  task automatic drive_idle();
    instr_ready_in = 0; instr_valid_in = 0; instr_in = 0;
    pf_jump_flag_in = 0; pf_jump_addr_in = 0; pf_instr_ready_in = 0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_addr"},    instr_addr_out, 32'h0);
    chk({tag, "_vld"},     instr_addr_valid_out, 0);
    chk({tag, "_pfvld"},   pf_instr_valid_out, 0);
    chk({tag, "_pfdat"},   pf_instr_out, 32'h0);
    chk({tag, "_pfaddr"},  pf_instr_addr_out, 32'h0);
    chk({tag, "_count"},   pf_count_out, 0);
    chk({tag, "_err"},     pf_err_out, 0);
  endtask

  task automatic check_outputs();
    chk("pf_valid", pf_instr_valid_out, exp_q.size() != 0);
    chk("pf_count", pf_count_out, exp_q.size());
    if (exp_q.size() != 0) begin
      chk("pf_addr", pf_instr_addr_out, exp_q[0].addr);
      chk("pf_data", pf_instr_out, exp_q[0].data);
    end
    chk("pf_err", pf_err_out, model_err);
    chk("outstanding_cap", mem_q.size() <= MAXO, 1);
    chk("occupancy_cap", (mem_q.size() + exp_q.size()) <= DEPTH, 1);
  endtask

  // One cycle: check outputs, pick inputs, and advance the model across the coming edge.
  task automatic step();
    bit          rdy, rv, cons, jmp, acc, pop;
    logic [31:0] rd, ja;
    req_t        r;
    @(negedge clk);
    check_outputs();
    rdy  = ($urandom_range(99) < rdy_pct);
    cons = ($urandom_range(99) < cons_pct);
    jmp  = jump_req || ($urandom_range(999) < jump_pm);
    ja   = jump_req ? jump_tgt : ($urandom & 32'h0000_FFFC);
    jump_req = 0;
    rv = 0; rd = $urandom;
    if (err_req) begin rv = 1; err_req = 0; end
    else if (mem_q.size() != 0 && mem_q[0].due <= cyc) begin rv = 1; rd = mem_q[0].data; end
    instr_ready_in = rdy; instr_valid_in = rv; instr_in = rd;
    pf_jump_flag_in = jmp; pf_jump_addr_in = ja; pf_instr_ready_in = cons;

    if (prev_hold) begin
      chk("req_hold_vld", instr_addr_valid_out, 1);
      chk("req_hold_addr", instr_addr_out, prev_addr);
    end else if (instr_addr_valid_out) begin
      chk("req_addr", instr_addr_out, exp_pc);
      req_epoch = epoch;
    end
    acc = instr_addr_valid_out && rdy;
    pop = pf_instr_valid_out && cons && !jmp;
    if (pop && exp_q.size() != 0) begin
      pop_log.push_back(exp_q[0].addr);
      exp_q.delete(0);
    end
    if (jmp) begin epoch++; exp_q.delete(); exp_pc = ja; end
    if (rv) begin
      if (mem_q.size() == 0) model_err = 1;
      else begin
        r = mem_q.pop_front();
        if (r.epoch == epoch) exp_q.push_back('{addr: r.addr, data: r.data});
      end
    end
    if (acc) begin
      r.addr = instr_addr_out; r.data = $urandom; r.epoch = req_epoch;
      r.due = cyc + 1 + lat_min + int'($urandom_range(lat_max - lat_min));
      mem_q.push_back(r);
      acc_log.push_back(instr_addr_out);
      if (req_epoch == epoch) exp_pc += 32'd4;
    end
    prev_hold = instr_addr_valid_out && !rdy;
    prev_addr = instr_addr_out;
    cyc++;
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst = 1; drive_idle(); model_reset();
    @(negedge clk);
    rst = 0;
  endtask

  task automatic knobs(input int r, input int c, input int j, input int lmin, input int lmax);
    rdy_pct = r; cons_pct = c; jump_pm = j; lat_min = lmin; lat_max = lmax;
  endtask

  initial begin
    tests = 0; fails = 0; cyc = 0; jump_req = 0; err_req = 0; jump_tgt = 0;
    knobs(100, 100, 0, 0, 0);
    rst = 1; drive_idle(); model_reset();
    #1 chk_reset_outputs("reset");
    @(negedge clk); @(negedge clk); rst = 0;

    // Streaming: sequential addresses, first delivered word is the reset pc.
    repeat (20) step();
    chk("A_acc_n", acc_log.size() >= 3, 1);
    if (acc_log.size() >= 3) begin
      chk("A_acc0", acc_log[0], 32'h0);
      chk("A_acc1", acc_log[1], 32'h4);
      chk("A_acc2", acc_log[2], 32'h8);
    end
    chk("A_pop_n", pop_log.size() >= 1, 1);
    if (pop_log.size() >= 1) chk("A_pop0", pop_log[0], 32'h0);

    // Consumer stalled: buffer fills to DEPTH, one pop buys exactly one request.
    reset_dut(); knobs(100, 0, 0, 0, 0);
    repeat (20) step();
    chk("B_acc_n", acc_log.size(), 4);
    chk("B_count", pf_count_out, 4);
    chk("B_reqvld", instr_addr_valid_out, 0);
    cons_pct = 100; step(); cons_pct = 0;
    repeat (10) step();
    chk("B_acc_n2", acc_log.size(), 5);
    if (acc_log.size() == 5) chk("B_acc4", acc_log[4], 32'h10);

    // Jump with two requests in flight: both replies dropped.
    reset_dut(); knobs(100, 100, 0, 5, 5);
    repeat (4) step();
    chk("C_outst", mem_q.size(), 2);
    jump_req = 1; jump_tgt = 32'h100; step();
    lat_min = 0; lat_max = 0;
    repeat (15) step();
    chk("C_pop_n", pop_log.size() >= 2, 1);
    if (pop_log.size() >= 2) begin
      chk("C_pop0", pop_log[0], 32'h100);
      chk("C_pop1", pop_log[1], 32'h104);
    end

    // Jump while a request waits unaccepted: it is held, completed, then discarded.
    reset_dut(); knobs(0, 100, 0, 0, 0);
    repeat (3) step();
    chk("D_pend_addr", instr_addr_out, 32'h0);
    chk("D_pend_vld", instr_addr_valid_out, 1);
    jump_req = 1; jump_tgt = 32'h200; step();
    for (int i = 0; i < 3; i++) begin
      step();
      chk("D_hold_addr", instr_addr_out, 32'h0);
      chk("D_hold_vld", instr_addr_valid_out, 1);
    end
    rdy_pct = 100;
    repeat (12) step();
    chk("D_acc_n", acc_log.size() >= 2, 1);
    if (acc_log.size() >= 2) begin
      chk("D_acc0", acc_log[0], 32'h0);
      chk("D_acc1", acc_log[1], 32'h200);
    end
    chk("D_pop_n", pop_log.size() >= 1, 1);
    if (pop_log.size() >= 1) chk("D_pop0", pop_log[0], 32'h200);

    // Response with nothing outstanding: sticky error, buffer untouched.
    reset_dut(); knobs(0, 0, 0, 0, 0);
    err_req = 1; step(); step();
    chk("E_err", pf_err_out, 1);
    chk("E_count", pf_count_out, 0);
    rdy_pct = 100; cons_pct = 100;
    repeat (6) step();
    chk("E_err_sticky", pf_err_out, 1);

    // Randomised traffic with jumps, then an asynchronous reset mid-burst.
    for (int k = 0; k < 6; k++) begin
      reset_dut();
      knobs(30 + 14 * k, 20 + 16 * k, (k % 3) * 40, 0, k % 4);
      repeat (1200) step();
    end
    knobs(100, 50, 30, 0, 2);
    repeat (40) step();
    #2 rst = 1; drive_idle();
    #1 chk_reset_outputs("async_rst");
    model_reset();
    @(negedge clk); rst = 0;
    knobs(80, 80, 20, 0, 3);
    repeat (300) step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
